streambuffer_mw: RTL

Parametrised successor to the stream buffer. It is a byte-granular circular buffer that accepts IBYTES-wide input beats. It drains through OOPT selectable pop widths, with full/empty flow control and a wrap-safe read window. It also adds an end-of-stream drain mode, which flushes a partial tail with a valid-byte length, and an occupancy output. It sits between the stream fetch engine and the SIMD lane consumers.

---
 rtl/streambuffer_pkg.sv | 17 +
 rtl/sb_bytering.sv | 36 +++
 rtl/streambuffer_mw.sv | 107 ++++++++++
 3 files changed

// File: rtl/streambuffer_pkg.sv
// Shared types and defaults for the multi-width stream buffer.
// popw(k) gives the byte width of pop option k.
package streambuffer_pkg;

  typedef logic [7:0] byte_t;

  localparam int IBYTES_DEF = 16;
  localparam int OBYTES_DEF = 64;
  localparam int OOPT_DEF   = 4;
  localparam int DEPTH_DEF  = 256;

  function automatic int popw(input int k, input int obytes = OBYTES_DEF,
                              input int oopt = OOPT_DEF);
    return obytes >> (oopt - 1 - k);
  endfunction

endpackage

// File: rtl/sb_bytering.sv
// Byte ring storage: one IBYTES-wide write port and one OBYTES-wide read window.
// Addresses wrap modulo DEPTH because the pointer width equals log2(DEPTH).
module sb_bytering
  import streambuffer_pkg::*;
#(
  parameter int IBYTES = IBYTES_DEF,
  parameter int OBYTES = OBYTES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           wptr,
  input  byte_t [IBYTES-1:0]      wdata,
  input  logic [AW-1:0]           rptr,
  output byte_t [OBYTES-1:0]      rdata
);

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < IBYTES; i++) begin
        mem[wptr + AW'(i)] <= wdata[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < OBYTES; i++) begin
      rdata[i] = mem[rptr + AW'(i)];
    end
  end

endmodule

// File: rtl/streambuffer_mw.sv
// Byte-granular circular stream buffer: IBYTES-wide pushes, OOPT selectable pop widths,
// end-of-stream drain that flushes a partial tail, and an occupancy output.
module streambuffer_mw
  import streambuffer_pkg::*;
#(
  parameter int IBYTES = IBYTES_DEF,
  parameter int OBYTES = OBYTES_DEF,
  parameter int OOPT   = OOPT_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ivalid,
  input  byte_t [IBYTES-1:0]       idata,
  input  logic                     ilast,
  output logic                     iready,
  output logic [OOPT-1:0]          ovalid,
  input  logic [OOPT-1:0]          oready,
  output byte_t [OBYTES-1:0]       odata,
  output logic [$clog2(OBYTES):0]  olen,
  output logic [CW-1:0]            level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(OBYTES) + 1;

  // Handshake: a beat moves when ivalid && iready; a pop of width k happens when
  // oready[k] && ovalid[k] and no lower k also qualifies. Ready/valid never look
  // at the opposite side's request, so no input-to-output combinational path exists.

  logic [AW-1:0]      wptr, rptr;
  logic [CW-1:0]      count, count_nxt, pop_amt;
  logic               draining, push, pop;
  byte_t [OBYTES-1:0] window;

  sb_bytering #(
    .IBYTES (IBYTES),
    .OBYTES (OBYTES),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ring (
    .clk   (clk),
    .we    (push),
    .wptr  (wptr),
    .wdata (idata),
    .rptr  (rptr),
    .rdata (window)
  );

  assign iready = rst && !draining && (count <= CW'(DEPTH - IBYTES));
  assign push   = ivalid && iready;

  // During drain any non-empty tail is poppable at every width.
  always_comb begin
    ovalid = '0;
    for (int k = 0; k < OOPT; k++) begin
      ovalid[k] = rst && ((count >= CW'(popw(k, OBYTES, OOPT))) ||
                          (draining && (count != CW'(0))));
    end
  end

  always_comb begin
    pop     = 1'b0;
    pop_amt = '0;
    for (int k = 0; k < OOPT; k++) begin
      if (!pop && oready[k] && ovalid[k]) begin
        pop     = 1'b1;
        pop_amt = (count < CW'(popw(k, OBYTES, OOPT))) ? count
                                                        : CW'(popw(k, OBYTES, OOPT));
      end
    end
  end

  assign count_nxt = count + (push ? CW'(IBYTES) : CW'(0)) - pop_amt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      draining <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(IBYTES);
      end
      rptr     <= rptr + pop_amt[AW-1:0];
      count    <= count_nxt;
      draining <= (draining || (push && ilast)) && (count_nxt != CW'(0));
    end
  end

  // Bytes beyond the occupancy are forced to zero so stale ring data never leaks.
  always_comb begin
    odata = '0;
    for (int i = 0; i < OBYTES; i++) begin
      if (rst && (CW'(i) < count)) begin
        odata[i] = window[i];
      end
    end
  end

  assign olen  = !rst ? LW'(0)
               : (count >= CW'(OBYTES)) ? LW'(OBYTES) : count[LW-1:0];
  assign level = rst ? count : CW'(0);

endmodule
